// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      INIT,
      LEN,
      DATA,
      WRITE,
      RUN
   } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into words: the first byte of each group
// lands in bits [7:0]. The completed word is presented combinationally in the
// cycle its last byte is taken, so the parent can register it on that edge.
module byte_packer
   import loader_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      take,
   input  logic [7:0]                byte_in,
   output logic [WORD_BYTES*8-1:0]   word,
   output logic                      word_done
);

   localparam int CW = $clog2(WORD_BYTES);
   localparam logic [CW-1:0] LAST_BYTE = CW'(WORD_BYTES - 1);

   logic [(WORD_BYTES-1)*8-1:0] shift_reg;
   logic [CW-1:0]               byte_cnt;

   assign word      = {byte_in, shift_reg};
   assign word_done = take && (byte_cnt == LAST_BYTE);

   // Shift each accepted byte in from the top and count bytes within the word;
   // clear drops any partially assembled word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
         byte_cnt  <= '0;
      end else if (clear) begin
         shift_reg <= '0;
         byte_cnt  <= '0;
      end else if (take) begin
         shift_reg <= word[WORD_BYTES*8-1:8];
         byte_cnt  <= byte_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed little-endian image, writes it word
// by word into instruction memory, then releases the core via run.
module program_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] START_ADDR = 32'h8000_0000,
   parameter int          DEPTH      = 12
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   output logic             s_ready,
   input  logic             reload,
   output logic [31:0]      insn_addr,
   output logic [31:0]      insn_din,
   output logic             insn_we,
   output logic             run,
   output logic             busy,
   output logic             err,
   output logic [DEPTH:0]   words_loaded
);

   localparam logic [32:0] MAX_WORDS = 33'd1 << DEPTH;

   loader_state_t state, state_next;
   logic [31:0]   len;
   logic [31:0]   word_idx;
   logic [31:0]   packed_word;
   logic          word_done;
   logic          take;

   assign s_ready = (state == LEN) || (state == DATA);
   assign busy    = s_ready || (state == WRITE);
   assign run     = (state == RUN);
   assign take    = s_valid && s_ready && !reload;

   byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (reload),
      .take      (take),
      .byte_in   (s_data),
      .word      (packed_word),
      .word_done (word_done)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= INIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; reload restarts from the header regardless of state.
   always_comb begin
      state_next = state;
      if (reload) begin
         state_next = LEN;
      end else begin
         case (state)
            INIT:    state_next = LEN;
            LEN:     if (word_done) state_next = (packed_word == 32'd0) ? RUN : DATA;
            DATA:    if (word_done) state_next = WRITE;
            WRITE:   state_next = ((word_idx + 32'd1) == len) ? RUN : DATA;
            RUN:     state_next = RUN;
            default: state_next = INIT;
         endcase
      end
   end

   // Header capture, overflow flag, write-port registers and word counters.
   // insn_we doubles as the "this word was actually written" flag in WRITE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len          <= '0;
         word_idx     <= '0;
         words_loaded <= '0;
         err          <= 1'b0;
         insn_we      <= 1'b0;
         insn_addr    <= START_ADDR;
         insn_din     <= '0;
      end else if (reload) begin
         len          <= '0;
         word_idx     <= '0;
         words_loaded <= '0;
         err          <= 1'b0;
         insn_we      <= 1'b0;
      end else begin
         insn_we <= 1'b0;
         case (state)
            LEN: begin
               if (word_done) begin
                  len <= packed_word;
                  if ({1'b0, packed_word} > MAX_WORDS) begin
                     err <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (word_done) begin
                  insn_din  <= packed_word;
                  insn_addr <= START_ADDR + (word_idx << 2);
                  insn_we   <= ({1'b0, word_idx} < MAX_WORDS);
               end
            end
            WRITE: begin
               word_idx <= word_idx + 32'd1;
               if (insn_we) begin
                  words_loaded <= words_loaded + (DEPTH+1)'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
